// File: rtl/fir_sample_server.sv
// fir_sample_server: sample history and coefficient store for a FIR engine.
// It buffers incoming samples in a circular window and serves registered
// coefficient and sample reads. A four-state FSM controls when new samples
// are accepted.
// Optional feature: define FIR_SRC_OVF_EN to enable the sticky s_ovf overrun
// flag. When the macro is undefined, s_ovf is tied to 0.
module fir_sample_server #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned H_ADDR_WIDTH = 4,
  parameter int unsigned X_ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_we,
  input  logic [H_ADDR_WIDTH-1:0] coef_waddr,
  input  logic [DATA_WIDTH-1:0]   coef_wdata,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  input  logic                    R_en,
  input  logic [H_ADDR_WIDTH-1:0] h_addr,
  input  logic [X_ADDR_WIDTH-1:0] x_addr,
  output logic [DATA_WIDTH-1:0]   h_i,
  output logic [DATA_WIDTH-1:0]   x_i,
  output logic                    rd_valid,
  output logic                    frame_rdy,
  output logic [X_ADDR_WIDTH:0]   fill_cnt,
  output logic                    coef_wr_err,
  output logic                    s_ovf
);

  localparam int unsigned HDepth = 2 ** H_ADDR_WIDTH;
  localparam int unsigned XDepth = 2 ** X_ADDR_WIDTH;
  // The window is armed once it holds as many samples as there are taps.
  localparam logic [X_ADDR_WIDTH:0]   ArmPrev  = (X_ADDR_WIDTH + 1)'(HDepth - 1);
  localparam logic [X_ADDR_WIDTH:0]   FillMax  = (X_ADDR_WIDTH + 1)'(XDepth);
  localparam logic [X_ADDR_WIDTH-1:0] PtrOne   = X_ADDR_WIDTH'(1);
  localparam logic [X_ADDR_WIDTH:0]   CntOne   = (X_ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StFill, StArmed, StBusy, StWait} state_t;

  state_t                    state;
  logic [X_ADDR_WIDTH-1:0]   wr_ptr;
  logic [X_ADDR_WIDTH-1:0]   rd_idx;
  logic                      accept;
  logic [DATA_WIDTH-1:0]     x_mem [XDepth];
  logic [DATA_WIDTH-1:0]     h_mem [HDepth];

  assign accept = s_valid && s_ready;
  // Offset 0 is the newest sample; uses the pre-write pointer on a same-cycle write.
  assign rd_idx = wr_ptr - PtrOne - x_addr;

  // Control FSM with registered s_ready / frame_rdy derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StFill;
      s_ready   <= 1'b0;
      frame_rdy <= 1'b0;
    end else begin
      unique case (state)
        StFill: begin
          s_ready   <= 1'b1;
          frame_rdy <= 1'b0;
          if (accept && fill_cnt == ArmPrev) begin
            state     <= StArmed;
            frame_rdy <= 1'b1;
          end
        end
        StArmed: begin
          if (R_en) begin
            state     <= StBusy;
            s_ready   <= 1'b0;
            frame_rdy <= 1'b0;
          end else begin
            s_ready   <= 1'b1;
            frame_rdy <= 1'b1;
          end
        end
        StBusy: begin
          if (!R_en) begin
            state     <= StWait;
            s_ready   <= 1'b1;
            frame_rdy <= 1'b0;
          end else begin
            s_ready   <= 1'b0;
            frame_rdy <= 1'b0;
          end
        end
        StWait: begin
          if (R_en) begin
            state     <= StBusy;
            s_ready   <= 1'b0;
            frame_rdy <= 1'b0;
          end else if (accept) begin
            state     <= StArmed;
            s_ready   <= 1'b1;
            frame_rdy <= 1'b1;
          end else begin
            s_ready   <= 1'b1;
            frame_rdy <= 1'b0;
          end
        end
        default: begin
          state     <= StFill;
          s_ready   <= 1'b1;
          frame_rdy <= 1'b0;
        end
      endcase
    end
  end

  // Sample history: circular write with saturating fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      for (int i = 0; i < int'(XDepth); i++) x_mem[i] <= '0;
    end else if (accept) begin
      x_mem[wr_ptr] <= s_data;
      wr_ptr        <= wr_ptr + PtrOne;
      if (fill_cnt != FillMax) fill_cnt <= fill_cnt + CntOne;
    end
  end

  // Coefficient table: writes are refused while a frame is being read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_wr_err <= 1'b0;
      for (int i = 0; i < int'(HDepth); i++) h_mem[i] <= '0;
    end else begin
      coef_wr_err <= coef_we && (state == StBusy);
      if (coef_we && state != StBusy) h_mem[coef_waddr] <= coef_wdata;
    end
  end

  // Registered read port; data holds when R_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      h_i      <= '0;
      x_i      <= '0;
    end else begin
      rd_valid <= R_en;
      if (R_en) begin
        h_i <= h_mem[h_addr];
        x_i <= x_mem[rd_idx];
      end
    end
  end

`ifdef FIR_SRC_OVF_EN
  // Sticky overrun: a sample offered while not ready is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ovf <= 1'b0;
    end else if (s_valid && !s_ready) begin
      s_ovf <= 1'b1;
    end
  end
`else
  assign s_ovf = 1'b0;
`endif

endmodule
